// File: rtl/lambda_peak_detect.sv
// Windowed argmax over the lambda metric stream, with a lock FSM that confirms a
// stable symbol-timing position and then tracks it until repeated misses.
module lambda_peak_detect #(
    parameter int unsigned WIN_LEN   = 80,
    parameter int unsigned IDX_W     = $clog2(WIN_LEN),
    parameter int unsigned TOL       = 1,
    parameter int unsigned CONFIRM_N = 3,
    parameter int unsigned MISS_N    = 2,
    parameter int unsigned LAMBDA_W  = 14
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic signed [LAMBDA_W-1:0] lambda_i,
    input  logic                       lambda_valid_i,
    output logic                       peak_valid_o,
    output logic [IDX_W-1:0]           peak_idx_o,
    output logic signed [LAMBDA_W-1:0] peak_val_o,
    output logic                       locked_o,
    output logic [IDX_W-1:0]           timing_idx_o
);
    localparam int unsigned DW    = IDX_W + 1;
    localparam int unsigned HitW  = $clog2(CONFIRM_N + 1);
    localparam int unsigned MissW = $clog2(MISS_N + 1);

    typedef enum logic [1:0] {StSearch, StConfirm, StLocked} state_e;

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            cnt_q, cnt_d;
    logic signed [LAMBDA_W-1:0]  max_val_q, max_val_d;
    logic [IDX_W-1:0]            max_idx_q, max_idx_d;
    logic                        peak_valid_q, peak_valid_d;
    logic [IDX_W-1:0]            peak_idx_q, peak_idx_d;
    logic signed [LAMBDA_W-1:0]  peak_val_q, peak_val_d;
    logic [IDX_W-1:0]            ref_idx_q, ref_idx_d;
    logic [HitW-1:0]             hit_cnt_q, hit_cnt_d, hit_inc;
    logic [MissW-1:0]            miss_cnt_q, miss_cnt_d, miss_inc;

    logic                        last;
    logic signed [LAMBDA_W-1:0]  cand_val;
    logic [IDX_W-1:0]            cand_idx;
    logic [DW-1:0]               diff, dist_a, dist_b;
    logic                        match;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StSearch;
            cnt_q        <= '0;
            max_val_q    <= '0;
            max_idx_q    <= '0;
            peak_valid_q <= 1'b0;
            peak_idx_q   <= '0;
            peak_val_q   <= '0;
            ref_idx_q    <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            max_val_q    <= max_val_d;
            max_idx_q    <= max_idx_d;
            peak_valid_q <= peak_valid_d;
            peak_idx_q   <= peak_idx_d;
            peak_val_q   <= peak_val_d;
            ref_idx_q    <= ref_idx_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Candidate includes the current sample so the last index of a window can win.
    always_comb begin
        last     = (cnt_q == IDX_W'(WIN_LEN - 1));
        cand_val = max_val_q;
        cand_idx = max_idx_q;
        if (cnt_q == '0) begin
            cand_val = lambda_i;
            cand_idx = '0;
        end else if (lambda_i > max_val_q) begin
            cand_val = lambda_i;
            cand_idx = cnt_q;
        end
        diff   = {1'b0, cand_idx} - {1'b0, ref_idx_q};
        dist_a = diff[IDX_W] ? -diff : diff;
        dist_b = DW'(WIN_LEN) - dist_a;
        match  = (dist_a <= DW'(TOL)) || (dist_b <= DW'(TOL));
        hit_inc  = hit_cnt_q + HitW'(1);
        miss_inc = miss_cnt_q + MissW'(1);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        max_val_d    = max_val_q;
        max_idx_d    = max_idx_q;
        peak_valid_d = 1'b0;
        peak_idx_d   = peak_idx_q;
        peak_val_d   = peak_val_q;
        ref_idx_d    = ref_idx_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (lambda_valid_i) begin
            max_val_d = cand_val;
            max_idx_d = cand_idx;
            cnt_d     = last ? '0 : cnt_q + IDX_W'(1);
            if (last) begin
                peak_valid_d = 1'b1;
                peak_idx_d   = cand_idx;
                peak_val_d   = cand_val;
                unique case (state_q)
                    StSearch: begin
                        ref_idx_d  = cand_idx;
                        hit_cnt_d  = HitW'(1);
                        miss_cnt_d = '0;
                        state_d    = (CONFIRM_N == 1) ? StLocked : StConfirm;
                    end
                    StConfirm: begin
                        ref_idx_d = cand_idx;
                        if (match) begin
                            hit_cnt_d = hit_inc;
                            if (hit_inc == HitW'(CONFIRM_N)) begin
                                state_d    = StLocked;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            hit_cnt_d = HitW'(1);
                        end
                    end
                    StLocked: begin
                        if (match) begin
                            ref_idx_d  = cand_idx;
                            miss_cnt_d = '0;
                        end else if (miss_inc == MissW'(MISS_N)) begin
                            state_d    = StSearch;
                            hit_cnt_d  = '0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_inc;
                        end
                    end
                    default: state_d = StSearch;
                endcase
            end
        end
    end

    assign peak_valid_o = peak_valid_q;
    assign peak_idx_o   = peak_idx_q;
    assign peak_val_o   = peak_val_q;
    assign locked_o     = (state_q == StLocked);
    assign timing_idx_o = ref_idx_q;

endmodule

// File: tb/tb_lambda_peak_detect.sv
// Directed bench for lambda_peak_detect: argmax, ties, signed compare, lock/unlock,
// wrap-around matching, input stalls and mid-window reset.
module tb_lambda_peak_detect;
    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic signed [13:0]  lambda = '0;
    logic                lambda_valid = 1'b0;
    logic                peak_valid;
    logic [6:0]          peak_idx;
    logic signed [13:0]  peak_val;
    logic                locked;
    logic [6:0]          timing_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cyc = 0;

    logic signed [13:0]  win [80];
    logic [6:0]          q_idx [$];
    logic signed [13:0]  q_val [$];
    logic                q_lock [$];
    logic [6:0]          q_tim [$];
    int                  q_cyc [$];

    lambda_peak_detect dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .lambda_i       (lambda),
        .lambda_valid_i (lambda_valid),
        .peak_valid_o   (peak_valid),
        .peak_idx_o     (peak_idx),
        .peak_val_o     (peak_val),
        .locked_o       (locked),
        .timing_idx_o   (timing_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && peak_valid) begin
            q_idx.push_back(peak_idx);
            q_val.push_back(peak_val);
            q_lock.push_back(locked);
            q_tim.push_back(timing_idx);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic clear_q();
        q_idx.delete(); q_val.delete(); q_lock.delete(); q_tim.delete(); q_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        lambda_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic set_win(input logic signed [13:0] base, input int idx,
                           input logic signed [13:0] val);
        for (int i = 0; i < 80; i++) win[i] = base;
        win[idx] = val;
    endtask

    task automatic stream(input int n, input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                @(negedge clk);
                lambda_valid = 1'b0;
                repeat (gap_len - 1) @(negedge clk);
            end
            @(negedge clk);
            if (i == 0) start_cyc = cyc;
            lambda_valid = 1'b1;
            lambda = win[i];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            lambda_valid = 1'b0;
        end
    endtask

    task automatic peak_window(input int idx);
        set_win(-14'sd100, idx, 14'sd500);
        stream(80, -1, 0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (peak_valid !== 1'b0) $display("FAIL rst_peak_valid: got %0d expected 0", peak_valid); else n_pass++;
        n_checks++; if (peak_idx !== 7'd0) $display("FAIL rst_peak_idx: got %0d expected 0", peak_idx); else n_pass++;
        n_checks++; if (peak_val !== 14'sd0) $display("FAIL rst_peak_val: got %0d expected 0", peak_val); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL rst_locked: got %0d expected 0", locked); else n_pass++;
        n_checks++; if (timing_idx !== 7'd0) $display("FAIL rst_timing_idx: got %0d expected 0", timing_idx); else n_pass++;
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic test_basic();
        do_reset();
        peak_window(37);
        idle(3);
        n_checks++; if (q_idx.size() != 1) $display("FAIL basic_pulses: got %0d expected 1", q_idx.size()); else n_pass++;
        n_checks++; if (q_idx[0] !== 7'd37) $display("FAIL basic_idx: got %0d expected 37", q_idx[0]); else n_pass++;
        n_checks++; if (q_val[0] !== 14'sd500) $display("FAIL basic_val: got %0d expected 500", q_val[0]); else n_pass++;
        n_checks++; if (q_lock[0] !== 1'b0) $display("FAIL basic_locked: got %0d expected 0", q_lock[0]); else n_pass++;
        n_checks++; if (peak_valid !== 1'b0) $display("FAIL basic_pulse_end: got %0d expected 0", peak_valid); else n_pass++;
        n_checks++; if (peak_idx !== 7'd37) $display("FAIL basic_idx_hold: got %0d expected 37", peak_idx); else n_pass++;
    endtask

    task automatic test_tie();
        do_reset();
        set_win(-14'sd1, 10, 14'sd300);
        win[55] = 14'sd300;
        stream(80, -1, 0);
        set_win(-14'sd1, 79, 14'sd400);
        win[10] = 14'sd300;
        stream(80, -1, 0);
        idle(2);
        n_checks++; if (q_idx.size() != 2) $display("FAIL tie_pulses: got %0d expected 2", q_idx.size()); else n_pass++;
        n_checks++; if (q_idx[0] !== 7'd10) $display("FAIL tie_idx: got %0d expected 10", q_idx[0]); else n_pass++;
        n_checks++; if (q_val[0] !== 14'sd300) $display("FAIL tie_val: got %0d expected 300", q_val[0]); else n_pass++;
        n_checks++; if (q_idx[1] !== 7'd79) $display("FAIL last_idx: got %0d expected 79", q_idx[1]); else n_pass++;
        n_checks++; if (q_val[1] !== 14'sd400) $display("FAIL last_val: got %0d expected 400", q_val[1]); else n_pass++;
    endtask

    task automatic test_signed();
        do_reset();
        set_win(-14'sd20, 5, -14'sd3);
        win[6] = -14'sd8192;
        stream(80, -1, 0);
        set_win(-14'sd20, 3, 14'sd1);
        win[5] = -14'sd3;
        stream(80, -1, 0);
        idle(2);
        n_checks++; if (q_idx.size() != 2) $display("FAIL signed_pulses: got %0d expected 2", q_idx.size()); else n_pass++;
        n_checks++; if (q_idx[0] !== 7'd5) $display("FAIL signed_neg_idx: got %0d expected 5", q_idx[0]); else n_pass++;
        n_checks++; if (q_val[0] !== -14'sd3) $display("FAIL signed_neg_val: got %0d expected -3", q_val[0]); else n_pass++;
        n_checks++; if (q_idx[1] !== 7'd3) $display("FAIL signed_mix_idx: got %0d expected 3", q_idx[1]); else n_pass++;
        n_checks++; if (q_val[1] !== 14'sd1) $display("FAIL signed_mix_val: got %0d expected 1", q_val[1]); else n_pass++;
    endtask

    task automatic test_lock();
        int seq [9]   = '{37, 38, 37, 60, 61, 20, 50, 51, 50};
        int e_lock [9] = '{0, 0, 1, 1, 0, 0, 0, 0, 1};
        int e_tim [9] = '{37, 38, 37, 37, 37, 20, 50, 51, 50};
        do_reset();
        for (int k = 0; k < 9; k++) peak_window(seq[k]);
        idle(2);
        n_checks++; if (q_idx.size() != 9) $display("FAIL lock_pulses: got %0d expected 9", q_idx.size()); else n_pass++;
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (q_lock[k] !== 1'(e_lock[k]))
                $display("FAIL lock_locked[%0d]: got %0d expected %0d", k, q_lock[k], e_lock[k]);
            else n_pass++;
            n_checks++;
            if (q_tim[k] !== 7'(e_tim[k]))
                $display("FAIL lock_timing[%0d]: got %0d expected %0d", k, q_tim[k], e_tim[k]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int seq [6]   = '{79, 79, 79, 0, 2, 2};
        int e_lock [6] = '{0, 0, 1, 1, 1, 0};
        int e_tim [6] = '{79, 79, 79, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 6; k++) peak_window(seq[k]);
        idle(2);
        n_checks++; if (q_idx.size() != 6) $display("FAIL wrap_pulses: got %0d expected 6", q_idx.size()); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (q_lock[k] !== 1'(e_lock[k]))
                $display("FAIL wrap_locked[%0d]: got %0d expected %0d", k, q_lock[k], e_lock[k]);
            else n_pass++;
            n_checks++;
            if (q_tim[k] !== 7'(e_tim[k]))
                $display("FAIL wrap_timing[%0d]: got %0d expected %0d", k, q_tim[k], e_tim[k]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        int s1, s2;
        do_reset();
        set_win(-14'sd100, 37, 14'sd500);
        stream(80, -1, 0);
        s1 = start_cyc;
        idle(2);
        stream(80, 40, 7);
        s2 = start_cyc;
        idle(2);
        n_checks++; if (q_idx.size() != 2) $display("FAIL stall_pulses: got %0d expected 2", q_idx.size()); else n_pass++;
        n_checks++; if (q_cyc[0] - s1 != 80) $display("FAIL gapless_latency: got %0d expected 80", q_cyc[0] - s1); else n_pass++;
        n_checks++; if (q_cyc[1] - s2 != 87) $display("FAIL stall_latency: got %0d expected 87", q_cyc[1] - s2); else n_pass++;
        n_checks++; if (q_idx[1] !== 7'd37) $display("FAIL stall_idx: got %0d expected 37", q_idx[1]); else n_pass++;
        n_checks++; if (q_val[1] !== 14'sd500) $display("FAIL stall_val: got %0d expected 500", q_val[1]); else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 3; k++) peak_window(37);
        idle(1);
        n_checks++; if (locked !== 1'b1) $display("FAIL mrst_pre_locked: got %0d expected 1", locked); else n_pass++;
        set_win(-14'sd100, 10, 14'sd900);
        stream(50, -1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        lambda_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (peak_valid !== 1'b0) $display("FAIL mrst_peak_valid: got %0d expected 0", peak_valid); else n_pass++;
        n_checks++; if (peak_idx !== 7'd0) $display("FAIL mrst_peak_idx: got %0d expected 0", peak_idx); else n_pass++;
        n_checks++; if (peak_val !== 14'sd0) $display("FAIL mrst_peak_val: got %0d expected 0", peak_val); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL mrst_locked: got %0d expected 0", locked); else n_pass++;
        n_checks++; if (timing_idx !== 7'd0) $display("FAIL mrst_timing: got %0d expected 0", timing_idx); else n_pass++;
        clear_q();
        set_win(-14'sd100, 3, 14'sd500);
        stream(80, -1, 0);
        s_idle_check();
    endtask

    task automatic s_idle_check();
        idle(2);
        n_checks++; if (q_idx.size() != 1) $display("FAIL mrst_pulses: got %0d expected 1", q_idx.size()); else n_pass++;
        n_checks++; if (q_idx[0] !== 7'd3) $display("FAIL mrst_next_idx: got %0d expected 3", q_idx[0]); else n_pass++;
        n_checks++; if (q_val[0] !== 14'sd500) $display("FAIL mrst_next_val: got %0d expected 500", q_val[0]); else n_pass++;
        n_checks++; if (q_tim[0] !== 7'd3) $display("FAIL mrst_next_timing: got %0d expected 3", q_tim[0]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_signed();
        test_lock();
        test_wrap();
        test_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lambda_peak_detect.md
# lambda_peak_detect

Symbol-timing decision stage directly downstream of the lambda (mag − rho·phi) stage. It scans the lambda stream in fixed windows of WIN_LEN samples and reports the argmax index and value of every window. A lock state machine declares symbol timing locked once the peak lands at a consistent circular position over CONFIRM_N consecutive windows. Once locked, it tracks that position and drops lock after MISS_N consecutive misses.

## Interface
- WIN_LEN, 80: samples per search window (N+L); ≥ 4
- IDX_W, $clog2(WIN_LEN): index width
- TOL, 1: max circular distance, in samples, for a peak to count as a match
- CONFIRM_N, 3: consecutive matching windows required to lock; ≥ 1
- MISS_N, 2: consecutive non-matching windows that drop lock; ≥ 1
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-low reset (0 = reset)
- lambda_in  in  LAMBDA_W (lambda_t, 14, signed Q6.8)  metric sample
- lambda_valid  in  1  lambda_in is a valid sample this cycle
- peak_valid  out  1  single-cycle pulse at window completion
- peak_idx  out  IDX_W  argmax position within the window just completed
- peak_val  out  LAMBDA_W  lambda value at peak_idx
- locked  out  1  timing locked
- timing_idx  out  IDX_W  tracked timing position; meaningful while locked=1

## Operation
- Sample counter cnt (0..WIN_LEN−1) advances only on lambda_valid and wraps WIN_LEN−1 → 0. A sample taken at cnt=k has index k.
- Running max:
  - At cnt=0, load max_val=lambda_in and max_idx=0 unconditionally.
  - Otherwise, update only when lambda_in > max_val (signed compare, strict). Ties keep the earliest index.
- When cnt=WIN_LEN−1 is accepted, the final candidate includes that last sample. peak_idx and peak_val are registered, and peak_valid pulses.
- Circular distance: d = |peak_idx − ref_idx| computed at IDX_W+1 bits; dist = min(d, WIN_LEN−d). A window matches when dist ≤ TOL.
- Lock FSM is evaluated only at window completion, using the new peak. Internal registers: ref_idx, hit_cnt, miss_cnt.
  - SEARCH: set ref_idx=peak_idx and hit_cnt=1. Go to LOCKED if CONFIRM_N==1, else CONFIRM.
  - CONFIRM, match: ref_idx=peak_idx, hit_cnt+1. On reaching CONFIRM_N, go to LOCKED with miss_cnt=0.
  - CONFIRM, mismatch: ref_idx=peak_idx, hit_cnt=1, stay in CONFIRM (restart on the new candidate).
  - LOCKED, match: ref_idx=peak_idx (tracks drift), miss_cnt=0.
  - LOCKED, mismatch: ref_idx unchanged, miss_cnt+1. On reaching MISS_N, go to SEARCH with hit_cnt=0 and miss_cnt=0.
- locked = (state==LOCKED). timing_idx = ref_idx.
- Gaps in lambda_valid stall the window. There is no timeout, and the partial max is held across the gap.

## Timing
- Reset (rst=0 at a clock edge) values:
  - cnt=0, max_val=0, max_idx=0.
  - peak_valid=0, peak_idx=0, peak_val=0.
  - state=SEARCH, locked=0, timing_idx=0.
- Reset mid-window discards the partial window. The first valid sample after release is index 0.
- peak_valid is high in the cycle after the edge that accepts sample WIN_LEN−1, i.e. 1-cycle latency. It is high for exactly 1 cycle.
- peak_idx and peak_val are held stable until the next window completes.
- locked and timing_idx update on the same edge as peak_valid rises, so they are coherent with the peak outputs in the peak_valid cycle.
- Back-to-back windows are fully supported. Sample 0 of the next window is accepted in the same cycle peak_valid is high, with no bubble.
- No backpressure; the block always accepts input.
- Upstream lambda carries fixed pipeline latency. This block adds no alignment of its own; index 0 is defined by the first valid sample after reset.

## Test plan
- Defaults. Stream 80 samples, all −100 except +500 at index 37 → one peak_valid pulse with peak_idx=37, peak_val=500, locked=0.
- Tie. Value 300 at indices 10 and 55, all others −1 → peak_idx=10. Repeat with a max at index 79 → peak_idx=79 (last sample included).
- Lock. Peaks at 37, 38, 37 in three consecutive windows → locked rises with the third peak_valid, timing_idx=37.
  - Then peaks 60, 61 → locked falls at the second miss, state is SEARCH.
  - The next window's peak restarts CONFIRM.
- Wrap-around match. Lock at ref 79, then peak at 0 (dist=1) → still locked, timing_idx=0. Peak at 2 from ref 0 (dist=2) counts as a miss.
- Stall and reset.
  - Deassert lambda_valid for 7 cycles at index 40 → peak result identical to the gapless run, with peak_valid delayed 7 cycles.
  - Pull rst=0 for one cycle at index 50 while locked → all outputs return to reset values, and the next window starts at index 0.
- Signed compare. Window of all-negative values with −3 the largest, at index 5 → peak_val=−3, peak_idx=5 (rules out an unsigned compare).
